// File: rtl/upc_checkout_seq.sv
// Clocked UPC checkout: synchronises a scan button, registers one item per press,
// flags discounted/stolen items from lookup masks and keeps saturating tallies plus a sticky alarm.
module upc_checkout_seq #(
  parameter int CODE_W = 3,
  parameter logic [(1<<CODE_W)-1:0] DISC_MASK = 8'b0100_1010,
  parameter logic [(1<<CODE_W)-1:0] EXP_MASK  = 8'b1010_0001,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] i_upc,
  input  logic              i_mark,
  input  logic              i_scan,
  input  logic              i_clear,
  output logic              o_disc,
  output logic              o_stole,
  output logic              o_alarm,
  output logic              o_valid,
  output logic [CODE_W-1:0] o_last_upc,
  output logic [CNT_W-1:0]  o_item_cnt,
  output logic [CNT_W-1:0]  o_disc_cnt,
  output logic [CNT_W-1:0]  o_stole_cnt
);

  typedef enum logic [1:0] {IDLE, CAPTURE, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, scan_prev_q;
  logic [CODE_W-1:0]   stage_upc_q, stage_upc_d;
  logic                stage_mark_q, stage_mark_d;
  logic                disc_q, disc_d;
  logic                stole_q, stole_d;
  logic                alarm_q, alarm_d;
  logic                valid_q, valid_d;
  logic [CODE_W-1:0]   last_upc_q, last_upc_d;
  logic [CNT_W-1:0]    item_cnt_q, item_cnt_d;
  logic [CNT_W-1:0]    disc_cnt_q, disc_cnt_d;
  logic [CNT_W-1:0]    stole_cnt_q, stole_cnt_d;
  logic                scan_s, scan_rise;
  logic                disc_eval, stole_eval;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  assign scan_s     = sync2_q;
  // Sync and edge flops reset high so a scan held through reset needs a fresh press.
  assign scan_rise  = scan_s & ~scan_prev_q;
  assign disc_eval  = DISC_MASK[stage_upc_q];
  assign stole_eval = EXP_MASK[stage_upc_q] & ~stage_mark_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      scan_prev_q  <= 1'b1;
      state_q      <= IDLE;
      stage_upc_q  <= '0;
      stage_mark_q <= 1'b0;
      disc_q       <= 1'b0;
      stole_q      <= 1'b0;
      alarm_q      <= 1'b0;
      valid_q      <= 1'b0;
      last_upc_q   <= '0;
      item_cnt_q   <= '0;
      disc_cnt_q   <= '0;
      stole_cnt_q  <= '0;
    end else begin
      sync1_q      <= i_scan;
      sync2_q      <= sync1_q;
      scan_prev_q  <= sync2_q;
      state_q      <= state_d;
      stage_upc_q  <= stage_upc_d;
      stage_mark_q <= stage_mark_d;
      disc_q       <= disc_d;
      stole_q      <= stole_d;
      alarm_q      <= alarm_d;
      valid_q      <= valid_d;
      last_upc_q   <= last_upc_d;
      item_cnt_q   <= item_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      stole_cnt_q  <= stole_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_upc_d  = stage_upc_q;
    stage_mark_d = stage_mark_q;
    disc_d       = disc_q;
    stole_d      = stole_q;
    alarm_d      = alarm_q;
    valid_d      = 1'b0;
    last_upc_d   = last_upc_q;
    item_cnt_d   = item_cnt_q;
    disc_cnt_d   = disc_cnt_q;
    stole_cnt_d  = stole_cnt_q;

    case (state_q)
      IDLE: begin
        if (scan_rise) begin
          state_d      = CAPTURE;
          stage_upc_d  = i_upc;
          stage_mark_d = i_mark;
        end
      end
      CAPTURE: begin
        state_d     = RELEASE;
        disc_d      = disc_eval;
        stole_d     = stole_eval;
        alarm_d     = alarm_q | stole_eval;
        valid_d     = 1'b1;
        last_upc_d  = stage_upc_q;
        item_cnt_d  = sat_inc(item_cnt_q, 1'b1);
        disc_cnt_d  = sat_inc(disc_cnt_q, disc_eval);
        stole_cnt_d = sat_inc(stole_cnt_q, stole_eval);
      end
      RELEASE: begin
        if (!scan_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides a coinciding capture, discarding that item entirely.
    if (i_clear) begin
      disc_d      = 1'b0;
      stole_d     = 1'b0;
      alarm_d     = 1'b0;
      valid_d     = 1'b0;
      last_upc_d  = '0;
      item_cnt_d  = '0;
      disc_cnt_d  = '0;
      stole_cnt_d = '0;
    end
  end

  assign o_disc      = disc_q;
  assign o_stole     = stole_q;
  assign o_alarm     = alarm_q;
  assign o_valid     = valid_q;
  assign o_last_upc  = last_upc_q;
  assign o_item_cnt  = item_cnt_q;
  assign o_disc_cnt  = disc_cnt_q;
  assign o_stole_cnt = stole_cnt_q;

endmodule

// File: tb/tb_upc_checkout_seq.sv
// Directed bench for upc_checkout_seq: hand-computed expectations for latency,
// mask lookup, saturation, single-shot pressing and clear/capture collision.
module tb_upc_checkout_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] i_upc;
  logic       i_mark;
  logic       i_scan;
  logic       i_clear;
  logic       o_disc, o_stole, o_alarm, o_valid;
  logic [2:0] o_last_upc;
  logic [3:0] o_item_cnt, o_disc_cnt, o_stole_cnt;

  int total = 0;
  int bad   = 0;
  int vcount = 0;

  upc_checkout_seq dut (
    .clk(clk), .rst_n(rst_n), .i_upc(i_upc), .i_mark(i_mark), .i_scan(i_scan),
    .i_clear(i_clear), .o_disc(o_disc), .o_stole(o_stole), .o_alarm(o_alarm),
    .o_valid(o_valid), .o_last_upc(o_last_upc), .o_item_cnt(o_item_cnt),
    .o_disc_cnt(o_disc_cnt), .o_stole_cnt(o_stole_cnt)
  );

  always #5 clk = ~clk;

  // Counts every o_valid pulse, sampled mid-cycle.
  always @(negedge clk) if (o_valid === 1'b1) vcount++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
  endtask

  // Presses, waits for o_valid (bounded), releases and lets the FSM return to IDLE.
  task automatic press(input logic [2:0] upc, input logic mark, output int lat);
    i_upc = upc; i_mark = mark; i_scan = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (o_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat == 0) begin
      bad++;
      $display("[TB] FAIL press_timeout: no o_valid within 20 cycles, required within 4");
    end
    i_scan = 1'b0;
    step(5);
  endtask

  task automatic test_reset();
    int base, lat;
    rst_n = 1'b0; i_scan = 1'b1; i_clear = 1'b0; i_upc = 3'd0; i_mark = 1'b0;
    step(3);
    rst_n = 1'b1;
    base = vcount;
    step(10);
    total++; if (o_item_cnt !== 4'd0 || o_disc_cnt !== 4'd0 || o_stole_cnt !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_counts: got %0d/%0d/%0d required 0/0/0", o_item_cnt, o_disc_cnt, o_stole_cnt);
    end
    total++; if ({o_disc, o_stole, o_alarm, o_valid, o_last_upc} !== 7'd0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b required 0000000", {o_disc, o_stole, o_alarm, o_valid, o_last_upc});
    end
    total++; if (vcount - base !== 0) begin
      bad++; $display("[TB] FAIL reset_held_scan: got %0d valid pulses required 0", vcount - base);
    end
    i_scan = 1'b0;
    step(5);
    base = vcount;
    press(3'd2, 1'b1, lat);
    total++; if (vcount - base !== 1) begin
      bad++; $display("[TB] FAIL reset_repress: got %0d valid pulses required 1", vcount - base);
    end
  endtask

  task automatic test_discount();
    int lat;
    do_clear();
    press(3'd1, 1'b0, lat);
    total++; if (lat !== 4) begin
      bad++; $display("[TB] FAIL disc_latency: got %0d edges required 4", lat);
    end
    total++; if ({o_disc, o_stole, o_alarm} !== 3'b100) begin
      bad++; $display("[TB] FAIL disc_flags: got %b required 100", {o_disc, o_stole, o_alarm});
    end
    total++; if (o_item_cnt !== 4'd1 || o_disc_cnt !== 4'd1 || o_last_upc !== 3'd1) begin
      bad++; $display("[TB] FAIL disc_counts: got item=%0d disc=%0d upc=%0d required 1/1/1", o_item_cnt, o_disc_cnt, o_last_upc);
    end
  endtask

  task automatic test_stolen();
    int lat;
    do_clear();
    press(3'd0, 1'b0, lat);
    total++; if ({o_stole, o_alarm} !== 2'b11 || o_stole_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL stole_first: got stole=%b alarm=%b cnt=%0d required 1/1/1", o_stole, o_alarm, o_stole_cnt);
    end
    press(3'd0, 1'b1, lat);
    total++; if ({o_stole, o_alarm} !== 2'b01 || o_item_cnt !== 4'd2 || o_stole_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL stole_marked: got stole=%b alarm=%b item=%0d scnt=%0d required 0/1/2/1", o_stole, o_alarm, o_item_cnt, o_stole_cnt);
    end
  endtask

  task automatic test_saturate();
    int lat;
    do_clear();
    for (int i = 0; i < 20; i++) press(3'd3, 1'b0, lat);
    total++; if (o_item_cnt !== 4'd15 || o_disc_cnt !== 4'd15 || o_stole_cnt !== 4'd0) begin
      bad++; $display("[TB] FAIL saturate: got %0d/%0d/%0d required 15/15/0", o_item_cnt, o_disc_cnt, o_stole_cnt);
    end
  endtask

  task automatic test_hold();
    int base;
    do_clear();
    base = vcount;
    i_upc = 3'd6; i_mark = 1'b1; i_scan = 1'b1;
    step(3);
    i_upc = 3'd2; i_mark = 1'b0;
    step(47);
    i_scan = 1'b0;
    step(5);
    total++; if (vcount - base !== 1) begin
      bad++; $display("[TB] FAIL hold_single: got %0d valid pulses required 1", vcount - base);
    end
    total++; if (o_last_upc !== 3'd6 || o_disc !== 1'b1 || o_stole !== 1'b0 || o_item_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL hold_latch: got upc=%0d disc=%b stole=%b item=%0d required 6/1/0/1", o_last_upc, o_disc, o_stole, o_item_cnt);
    end
  endtask

  task automatic test_clear_on_capture();
    int base, lat;
    do_clear();
    base = vcount;
    i_upc = 3'd5; i_mark = 1'b0; i_scan = 1'b1;
    step(3);
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    i_scan = 1'b0;
    step(5);
    total++; if (vcount - base !== 0) begin
      bad++; $display("[TB] FAIL clear_cap_valid: got %0d valid pulses required 0", vcount - base);
    end
    total++; if (o_item_cnt !== 4'd0 || o_stole_cnt !== 4'd0 || o_alarm !== 1'b0 || o_stole !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_cap_state: got item=%0d scnt=%0d alarm=%b stole=%b required 0/0/0/0", o_item_cnt, o_stole_cnt, o_alarm, o_stole);
    end
    press(3'd5, 1'b0, lat);
    total++; if ({o_stole, o_alarm} !== 2'b11 || o_item_cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL clear_then_press: got stole=%b alarm=%b item=%0d required 1/1/1", o_stole, o_alarm, o_item_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_discount();
    test_stolen();
    test_saturate();
    test_hold();
    test_clear_on_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upc_checkout_seq.md
Name: upc_checkout_seq

Overview:
- Clocked, parametrised successor to the combinational UPC discount/stolen checker.
- Registers one item per scan event, with a 2-flop synchroniser and a press/release state machine on the scan input.
- Evaluates discount/stolen from parametrised lookup masks, keeps saturating item/discount/theft tallies and latches a theft alarm until cleared.
- Instantiated under DE1_SoC: SW drives i_upc/i_mark, a KEY drives i_scan, LEDR shows the flags and alarm.

Parameters:
- CODE_W, 3, UPC code width in bits; the table has 2**CODE_W entries.
- DISC_MASK, 8'b0100_1010, width 2**CODE_W; bit k=1 means code k is discounted.
- EXP_MASK, 8'b1010_0001, width 2**CODE_W; bit k=1 means code k is expensive, so stolen if unmarked.
- CNT_W, 4, width of each tally counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_upc  in  CODE_W  item code; must be stable while i_scan is high
- i_mark  in  1  item carries the security mark
- i_scan  in  1  asynchronous scan request, active high (level, e.g. inverted KEY)
- i_clear  in  1  synchronous clear of tallies and alarm
- o_disc  out  1  last item discounted
- o_stole  out  1  last item stolen
- o_alarm  out  1  sticky theft alarm
- o_valid  out  1  one-cycle pulse when a new item result is registered
- o_last_upc  out  CODE_W  code of last registered item
- o_item_cnt  out  CNT_W  items scanned (saturating)
- o_disc_cnt  out  CNT_W  discounted items (saturating)
- o_stole_cnt  out  CNT_W  stolen items (saturating)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Synchroniser flops reset to 1, so a scan held across reset does not register until released and pressed again.
- Synchroniser: scan_s = second flop of a 2-flop chain on i_scan.
- FSM states are IDLE, CAPTURE and RELEASE:
  - IDLE: if scan_s=1, go to CAPTURE and latch i_upc/i_mark into staging registers on that edge.
  - CAPTURE: exactly one cycle. On exiting, the edge updates all result registers and asserts o_valid; next state is RELEASE.
  - RELEASE: stay while scan_s=1; go to IDLE when scan_s=0. This gives one item per press; no auto-repeat.
- Latency:
  - i_scan is first sampled high at edge E0, and scan_s=1 after E1.
  - CAPTURE is entered at E2; results and o_valid are visible after E3.
  - o_valid drops after E4.
- Evaluation on the staged code c and mark m:
  - disc = DISC_MASK[c].
  - stole = EXP_MASK[c] & ~m.
  - o_disc/o_stole/o_last_upc hold their value until the next capture, a clear or a reset.
- Tallies:
  - o_item_cnt += 1, o_disc_cnt += disc, o_stole_cnt += stole on each capture.
  - Each counter saturates at 2**CNT_W-1; there is no wrap.
- Alarm: set when a capture has stole=1; stays set until i_clear or reset.
- i_clear:
  - Zeroes the three counters, o_alarm, o_disc, o_stole and o_last_upc.
  - The FSM state is unaffected.
  - If i_clear coincides with the CAPTURE update edge, clear wins: the item is discarded and o_valid stays 0.
- rst_n has priority over i_clear. Reset during CAPTURE or RELEASE returns to IDLE with no partial update.
- i_upc/i_mark changes outside the IDLE->CAPTURE latch edge have no effect.

Test Plan:
- Reset with i_scan=1 held, then run 10 cycles -> outputs all 0, no o_valid; release then press -> exactly one o_valid.
- i_upc=3'd1, i_mark=0, one press -> o_valid once, 3 cycles after first sample; o_disc=1, o_stole=0, o_item_cnt=1, o_disc_cnt=1, o_alarm=0.
- i_upc=3'd0, i_mark=0 -> o_stole=1, o_alarm=1, o_stole_cnt=1. Then i_upc=3'd0, i_mark=1 -> o_stole=0, o_alarm stays 1, o_item_cnt=2.
- 20 presses of i_upc=3'd3, i_mark=0 -> o_item_cnt=15 and o_disc_cnt=15 (saturated), o_stole_cnt=0.
- Hold i_scan high for 50 cycles -> exactly one o_valid. Change i_upc while held -> o_last_upc keeps the value latched at the IDLE->CAPTURE edge.
- i_clear asserted on the CAPTURE update edge with i_upc=3'd5, i_mark=0 -> no o_valid, counters 0, o_alarm=0. A later press of 3'd5 -> o_stole=1, o_alarm=1.
